wdt_servicer: RTL and testbench

// - Servicing end of the watchdog interface: drives the watchdog's enable/restart, consumes its timeout.
// - Kicks (restart) every KICK_PERIOD cycles only while the supervised task pulses heartbeat.
// - Missed heartbeats starve the watchdog; on timeout, holds a system reset request and counts faults.

---
 rtl/wdt_servicer_if.sv | 13 +
 rtl/wdt_servicer.sv | 162 ++++++++++++++++
 tb/tb_wdt_servicer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wdt_servicer_if.sv
// Watchdog link between the servicer and a watchdog timer.
//   restart  : one-cycle restart pulse toward the watchdog
//   enable   : watchdog enable level
//   timeout  : watchdog timeout level back to the servicer
// master = servicing side (wdt_servicer), slave = watchdog side.
interface wdt_servicer_if;
  logic restart;
  logic enable;
  logic timeout;

  modport master (output restart, output enable, input timeout);
  modport slave  (input restart, input enable, output timeout);
endinterface

// File: rtl/wdt_servicer.sv
// Watchdog servicer: keeps a watchdog fed while the supervised task shows signs of life.
// A restart is issued once per KICK_PERIOD cycles, but only if a heartbeat arrived in that
// period. After MISS_LIMIT empty periods the watchdog is starved; on its timeout a system
// reset request is held for RESET_CYCLES cycles and a saturating fault counter increments.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   svc_en         servicing enable level
//   heartbeat      one-cycle pulse from the supervised task
//   wd             watchdog link (restart/enable out, timeout in), registered outputs
//   sys_reset_req  system reset request, registered
//   fault_count    saturating count of faults
//
// Build option: define WDT_SVC_WINDOW_EN for windowed servicing, where a heartbeat earlier
// than MIN_GAP cycles into a period is treated like a timeout.
module wdt_servicer #(
  parameter int unsigned KICK_PERIOD  = 8,
  parameter int unsigned MISS_LIMIT   = 2,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned FAULT_W      = 4,
  parameter int unsigned MIN_GAP      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               svc_en,
  input  logic               heartbeat,
  wdt_servicer_if.master     wd,
  output logic               sys_reset_req,
  output logic [FAULT_W-1:0] fault_count
);

  if (KICK_PERIOD < 2 || KICK_PERIOD > 14 || MISS_LIMIT < 1 || MISS_LIMIT > 7 ||
      RESET_CYCLES < 1 || RESET_CYCLES > 15 || MIN_GAP >= KICK_PERIOD) begin : g_bad_params
    $error("wdt_servicer: parameter out of range");
  end

  typedef enum logic [2:0] {StIdle, StArm, StRun, StStarve, StFault} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2:0]         miss_q, miss_d;
  logic               hb_seen_q, hb_seen_d;
  logic [3:0]         rst_cnt_q, rst_cnt_d;
  logic               restart_q, restart_d;
  logic               enable_q, enable_d;
  logic               srr_q, srr_d;
  logic [FAULT_W-1:0] fault_q, fault_d;

  logic boundary;
  logic early;
  logic trip;

  assign boundary = (cnt_q == 4'(KICK_PERIOD - 1));

`ifdef WDT_SVC_WINDOW_EN
  // A heartbeat too soon after the period start means the task is running away.
  assign early = (state_q == StRun) && heartbeat && (cnt_q < 4'(MIN_GAP));
`else
  assign early = 1'b0;
`endif

  assign trip = wd.timeout | early;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    miss_d    = miss_q;
    hb_seen_d = hb_seen_q;
    rst_cnt_d = rst_cnt_q;
    fault_d   = fault_q;
    restart_d = 1'b0;
    enable_d  = 1'b0;
    srr_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (svc_en) state_d = StArm;
      end
      StArm: begin
        if (!svc_en) begin
          state_d = StIdle;
        end else begin
          state_d   = StRun;
          restart_d = 1'b1;
          enable_d  = 1'b1;
          cnt_d     = '0;
          miss_d    = '0;
          hb_seen_d = 1'b0;
        end
      end
      StRun, StStarve: begin
        // Priority: servicing disabled > timeout/early kick > period boundary.
        if (!svc_en) begin
          state_d = StIdle;
        end else if (trip) begin
          state_d   = StFault;
          srr_d     = 1'b1;
          rst_cnt_d = '0;
          if (fault_q != {FAULT_W{1'b1}}) fault_d = fault_q + 1'b1;
        end else begin
          enable_d = 1'b1;
          if (state_q == StRun) begin
            if (boundary) begin
              cnt_d     = '0;
              hb_seen_d = 1'b0;
              // A heartbeat landing in the boundary cycle still earns this period's kick.
              if (hb_seen_q || heartbeat) begin
                restart_d = 1'b1;
                miss_d    = '0;
              end else begin
                miss_d = miss_q + 3'd1;
                if (miss_q + 3'd1 == 3'(MISS_LIMIT)) state_d = StStarve;
              end
            end else begin
              cnt_d     = cnt_q + 4'd1;
              hb_seen_d = hb_seen_q | heartbeat;
            end
          end
        end
      end
      StFault: begin
        if (rst_cnt_q == 4'(RESET_CYCLES - 1)) begin
          state_d = svc_en ? StArm : StIdle;
        end else begin
          rst_cnt_d = rst_cnt_q + 4'd1;
          srr_d     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      miss_q    <= '0;
      hb_seen_q <= 1'b0;
      rst_cnt_q <= '0;
      restart_q <= 1'b0;
      enable_q  <= 1'b0;
      srr_q     <= 1'b0;
      fault_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      miss_q    <= miss_d;
      hb_seen_q <= hb_seen_d;
      rst_cnt_q <= rst_cnt_d;
      restart_q <= restart_d;
      enable_q  <= enable_d;
      srr_q     <= srr_d;
      fault_q   <= fault_d;
    end
  end

  assign wd.restart    = restart_q;
  assign wd.enable     = enable_q;
  assign sys_reset_req = srr_q;
  assign fault_count   = fault_q;

endmodule

// File: tb/tb_wdt_servicer.sv
module tb_wdt_servicer;
  localparam int KP   = 8;
  localparam int ML   = 2;
  localparam int RC   = 4;
  localparam int FW   = 4;
  localparam int MG   = 3;
  localparam int FMAX = (1 << FW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          svc_en = 1'b0;
  logic          heartbeat = 1'b0;
  logic          sys_reset_req;
  logic [FW-1:0] fault_count;

  wdt_servicer_if wd ();

  wdt_servicer #(
    .KICK_PERIOD (KP),
    .MISS_LIMIT  (ML),
    .RESET_CYCLES(RC),
    .FAULT_W     (FW),
    .MIN_GAP     (MG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .svc_en       (svc_en),
    .heartbeat    (heartbeat),
    .wd           (wd),
    .sys_reset_req(sys_reset_req),
    .fault_count  (fault_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 1'b0;
  int wd_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 arming, 2 running, 3 starving, 4 resetting system.
  // Expected outputs hold what the DUT must show during the cycle after each edge.
  int m_mode = 0, m_age = 0, m_miss = 0, m_fleft = 0, m_fc = 0;
  bit m_hb = 0, m_rs = 0, m_en = 0, m_srr = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int md, age, miss, fl, fc;
    bit hb, rs, en, srr, early;
    if (!rst_n) begin
      m_mode <= 0; m_age <= 0; m_miss <= 0; m_fleft <= 0; m_fc <= 0;
      m_hb <= 0; m_rs <= 0; m_en <= 0; m_srr <= 0;
    end else begin
      md = m_mode; age = m_age; miss = m_miss; fl = m_fleft; fc = m_fc; hb = m_hb;
      rs = 0; en = 0; srr = 0; early = 0;
`ifdef WDT_SVC_WINDOW_EN
      early = (md == 2) && heartbeat && ((age % KP) < MG);
`endif
      case (md)
        0: if (svc_en) md = 1;
        1: begin
          if (svc_en) begin
            md = 2; rs = 1; en = 1; age = 0; miss = 0; hb = 0;
          end else md = 0;
        end
        2, 3: begin
          if (!svc_en) md = 0;
          else if (wd.timeout || early) begin
            md = 4; fl = RC; srr = 1;
            if (fc < FMAX) fc++;
          end else begin
            en = 1;
            if (md == 2) begin
              if (age % KP == KP - 1) begin
                if (hb || heartbeat) begin rs = 1; miss = 0; end
                else begin
                  miss++;
                  if (miss == ML) md = 3;
                end
                hb = 0;
              end else hb = hb || heartbeat;
              age++;
            end
          end
        end
        default: begin
          fl--;
          if (fl == 0) md = svc_en ? 1 : 0;
          else srr = 1;
        end
      endcase
      m_mode <= md; m_age <= age; m_miss <= miss; m_fleft <= fl; m_fc <= fc;
      m_hb <= hb; m_rs <= rs; m_en <= en; m_srr <= srr;
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("restart", wd.restart, m_rs);
      chk("enable", wd.enable, m_en);
      chk("sys_reset_req", sys_reset_req, m_srr);
      chk("fault_count", fault_count, m_fc);
    end
  end

  // Drive one cycle of inputs; the bench watchdog clears on restart or while disabled and
  // times out 15 cycles after its last clear. f forces a timeout for this cycle.
  task automatic cyc(input bit s, input bit h, input bit f);
    svc_en = s;
    heartbeat = h;
    if (!wd.enable || wd.restart) wd_cnt = 0;
    else if (wd_cnt < 15) wd_cnt++;
    wd.timeout = f | (wd.enable && wd_cnt >= 15);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rs(input string nm, input int lim);
    for (int j = 0; j < lim && !wd.restart; j++) cyc(1, 0, 0);
    chk(nm, wd.restart, 1);
  endtask

  initial begin
    int nrs, tmax, last_rs, rise, high, rearm;
    wd.timeout = 1'b0;
    #12;
    chk("reset_restart", wd.restart, 0);
    chk("reset_enable", wd.enable, 0);
    chk("reset_srr", sys_reset_req, 0);
    chk("reset_fc", fault_count, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Steady servicing: heartbeat mid-period, one kick every KP cycles.
    wait_rs("first_restart", 6);
    nrs = 0;
    tmax = 0;
    for (int i = 0; i < 200; i++) begin
      if (wd.restart) nrs++;
      if (wd.timeout) tmax = 1;
      cyc(1, (i % KP) == 4, 0);
    end
    chk("steady_restarts", nrs, 25);
    chk("steady_timeout", tmax, 0);
    chk("steady_fc", fault_count, 0);

    // Starvation: last kick to reset request is 16 cycles, request lasts RC cycles.
    last_rs = -1; rise = -1; high = 0; rearm = 0;
    for (int i = 0; i < 30; i++) begin
      if (wd.restart) begin
        if (rise < 0) last_rs = i;
        else if (high > 0 && !sys_reset_req) rearm = 1;
      end
      if (sys_reset_req) begin
        if (rise < 0) rise = i;
        high++;
      end
      cyc(1, 0, 0);
    end
    chk("starve_latency", rise - last_rs, 16);
    chk("starve_srr_len", high, RC);
    chk("starve_fc", fault_count, 1);
    chk("starve_rearm", rearm, 1);

    // Heartbeat only in the boundary cycle still earns the kick.
    wait_rs("sync_restart", 45);
    nrs = 0;
    for (int i = 0; i <= 24; i++) begin
      if (i > 0 && wd.restart) nrs++;
      cyc(1, (i % KP) == KP - 1, 0);
    end
    chk("boundary_hb_restarts", nrs, 3);

    // Dropping svc_en stops servicing at once; raising it re-arms.
    cyc(0, 0, 0);
    chk("drop_enable", wd.enable, 0);
    nrs = 0;
    for (int i = 0; i < 10; i++) begin
      if (wd.restart) nrs++;
      cyc(0, 0, 0);
    end
    chk("drop_no_restart", nrs, 0);
    cyc(1, 0, 0);
    wait_rs("reraise_restart", 5);

    // Sixteen forced faults saturate the counter.
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 10 && !wd.enable; j++) cyc(1, 0, 0);
      cyc(1, 0, 1);
      repeat (RC + 1) cyc(1, 0, 0);
    end
    chk("fc_saturated", fault_count, FMAX);

`ifdef WDT_SVC_WINDOW_EN
    wait_rs("win_sync", 20);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("win_early_fault", sys_reset_req, 1);
    repeat (RC + 1) cyc(1, 0, 0);
    wait_rs("win_resync", 5);
    repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 0);
    repeat (4) cyc(1, 0, 0);
    chk("win_normal_kick", wd.restart, 1);
`endif

    // Reset in the middle of a fault clears everything immediately.
    for (int j = 0; j < 10 && !wd.enable; j++) cyc(1, 0, 0);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    chk("midfault_srr", sys_reset_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midfault_rst_restart", wd.restart, 0);
    chk("midfault_rst_enable", wd.enable, 0);
    chk("midfault_rst_srr", sys_reset_req, 0);
    chk("midfault_rst_fc", fault_count, 0);
    #2 rst_n = 1'b1;
    wd_cnt = 0;
    @(posedge clk);
    #1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 63) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 199) == 0);
    end

    @(posedge clk);
    #1;
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
